// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART ALU command protocol: master FSM states,
// frame byte order and the opcode map common to the responder and the ALU.
package alu_uart_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND_A  = 3'd1;
  localparam logic [2:0] S_SEND_B  = 3'd2;
  localparam logic [2:0] S_SEND_OP = 3'd3;
  localparam logic [2:0] S_WAIT_RX = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    SEND_A  = S_SEND_A,
    SEND_B  = S_SEND_B,
    SEND_OP = S_SEND_OP,
    WAIT_RX = S_WAIT_RX,
    DONE    = S_DONE
  } state_t;

  localparam int unsigned BYTE_A      = 0;
  localparam int unsigned BYTE_B      = 1;
  localparam int unsigned BYTE_OP     = 2;
  localparam int unsigned FRAME_BYTES = 3;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/alu_uart_timeout_counter.sv
// Saturating response-wait counter; flags the last allowed cycle of the wait.
// LIMIT of 0 means the wait never expires.
module alu_uart_timeout_counter #(
  parameter int unsigned LIMIT = 100000,
  localparam int unsigned W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge i_clock) begin
    if (!i_reset || i_clear) count <= '0;
    else if (i_enable && count != '1) count <= count + 1'b1;
  end

  assign o_expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/alu_uart_master.sv
// Host-side initiator: sends A, B, opcode to the remote ALU over the UART
// FIFOs, then waits (with timeout) for the single result byte.
module alu_uart_master
  import alu_uart_pkg::*;
#(
  parameter int unsigned BUS_SIZE       = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [BUS_SIZE-1:0] i_data_a,
  input  logic [BUS_SIZE-1:0] i_data_b,
  input  logic [NB_OP-1:0]    i_opcode,
  output logic [BUS_SIZE-1:0] o_w_data,
  output logic                o_wr_uart,
  input  logic                i_tx_full,
  input  logic [BUS_SIZE-1:0] i_r_data,
  output logic                o_rd_uart,
  input  logic                i_rx_empty,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic                o_stray,
  output logic [BUS_SIZE-1:0] o_result
);

  state_t state, state_n;
  logic [FRAME_BYTES-1:0][BUS_SIZE-1:0] frame;
  logic wr, rd, tmo_clear, tmo_en, tmo_expired, timeout_hit;

  alu_uart_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (tmo_clear),
    .i_enable (tmo_en),
    .o_expired(tmo_expired)
  );

  // Strobes are held low during reset so a reset mid-frame never touches the FIFOs.
  always_comb begin
    state_n     = state;
    wr          = 1'b0;
    rd          = 1'b0;
    o_w_data    = '0;
    tmo_clear   = 1'b0;
    tmo_en      = 1'b0;
    timeout_hit = 1'b0;
    if (i_reset) begin
      case (state)
        IDLE: begin
          rd = ~i_rx_empty;
          if (i_start) state_n = SEND_A;
        end
        SEND_A: begin
          o_w_data = frame[BYTE_A];
          wr       = ~i_tx_full;
          if (wr) state_n = SEND_B;
        end
        SEND_B: begin
          o_w_data = frame[BYTE_B];
          wr       = ~i_tx_full;
          if (wr) state_n = SEND_OP;
        end
        SEND_OP: begin
          o_w_data = frame[BYTE_OP];
          wr       = ~i_tx_full;
          if (wr) begin
            state_n   = WAIT_RX;
            tmo_clear = 1'b1;
          end
        end
        WAIT_RX: begin
          // A byte present on the limit cycle takes priority over the timeout.
          if (!i_rx_empty) begin
            rd      = 1'b1;
            state_n = DONE;
          end else if (tmo_expired) begin
            timeout_hit = 1'b1;
            state_n     = IDLE;
          end else begin
            tmo_en = 1'b1;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state     <= IDLE;
      frame     <= '0;
      o_result  <= '0;
      o_timeout <= 1'b0;
      o_stray   <= 1'b0;
    end else begin
      state     <= state_n;
      o_timeout <= timeout_hit;
      o_stray   <= (state == IDLE) && !i_rx_empty;
      if (state == IDLE && i_start) begin
        frame[BYTE_A]  <= i_data_a;
        frame[BYTE_B]  <= i_data_b;
        frame[BYTE_OP] <= BUS_SIZE'(i_opcode);
      end
      if (state == WAIT_RX && !i_rx_empty) o_result <= i_r_data;
    end
  end

  assign o_wr_uart = wr;
  assign o_rd_uart = rd;
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);

endmodule

// File: tb/tb_alu_uart_master.sv
// Bench for alu_uart_master: transaction-level model with FIFO queues,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_alu_uart_master;
  import alu_uart_pkg::*;

  localparam int TMO = 16;

  logic       i_clock = 1'b0, i_reset = 1'b0, i_start = 1'b0;
  logic [7:0] i_data_a = '0, i_data_b = '0;
  logic [5:0] i_opcode = '0;
  logic       i_tx_full = 1'b0, i_rx_empty = 1'b1;
  logic [7:0] i_r_data = '0;
  logic [7:0] o_w_data, o_result;
  logic       o_wr_uart, o_rd_uart, o_busy, o_done, o_timeout, o_stray;

  alu_uart_master #(.BUS_SIZE(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_opcode(i_opcode),
    .o_w_data(o_w_data), .o_wr_uart(o_wr_uart), .i_tx_full(i_tx_full),
    .i_r_data(i_r_data), .o_rd_uart(o_rd_uart), .i_rx_empty(i_rx_empty),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_stray(o_stray), .o_result(o_result)
  );

  always #5 i_clock = ~i_clock;

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;

  // Model: bytes still to transmit, waiting-for-reply flag with age, pulses.
  logic [7:0] rxq[$], m_txq[$], wlog[$];
  bit         m_wait = 0, m_done = 0, m_tmo = 0, m_stray = 0;
  int         m_age = 0;
  logic [7:0] m_result = '0;
  int         n_done = 0, n_tmo = 0, n_stray = 0, last_wr_cyc = 0, tmo_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_idle();
    return m_txq.size() == 0 && !m_wait && !m_done;
  endfunction

  // Advance the model by one clock edge, using the inputs as seen at that edge.
  task automatic model_step();
    bit idle, empty, nd, nt;
    idle  = m_idle();
    empty = (rxq.size() == 0);
    nd = 0; nt = 0;
    if (!i_reset) begin
      m_txq.delete();
      m_wait = 0; m_age = 0; m_done = 0; m_tmo = 0; m_stray = 0; m_result = '0;
      return;
    end
    m_stray = idle && !empty;
    if (idle) begin
      if (!empty) void'(rxq.pop_front());
      if (i_start) begin
        m_txq.push_back(i_data_a);
        m_txq.push_back(i_data_b);
        m_txq.push_back({2'b00, i_opcode});
      end
    end else if (m_txq.size() != 0) begin
      if (!i_tx_full) begin
        void'(m_txq.pop_front());
        if (m_txq.size() == 0) begin m_wait = 1; m_age = 0; end
      end
    end else if (m_wait) begin
      if (!empty) begin
        m_result = rxq.pop_front();
        m_wait = 0; nd = 1;
      end else if (TMO != 0 && m_age == TMO - 1) begin
        m_wait = 0; nt = 1;
      end else m_age++;
    end
    m_done = nd;
    m_tmo  = nt;
  endtask

  task automatic drive_rx();
    i_rx_empty = (rxq.size() == 0);
    i_r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge i_clock);
    model_step();
    #1;
    cyc++;
    drive_rx();
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    drive_rx();
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_data_a = a; i_data_b = b; i_opcode = op; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_wait(input int bound);
    for (int i = 0; i < bound && !m_wait; i++) tick();
    if (!m_wait) chk("reach_wait_rx", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && !m_idle(); i++) tick();
    if (!m_idle()) chk("reach_idle", 0, 1);
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge i_clock) begin
    bit idle, empty;
    if (chk_en) begin
      idle  = m_idle();
      empty = (rxq.size() == 0);
      chk("busy",    o_busy,    !idle);
      chk("done",    o_done,    m_done);
      chk("timeout", o_timeout, m_tmo);
      chk("stray",   o_stray,   m_stray);
      chk("result",  o_result,  m_result);
      chk("wr_uart", o_wr_uart, i_reset && m_txq.size() != 0 && !i_tx_full);
      chk("rd_uart", o_rd_uart, i_reset && !empty && (idle || m_wait));
      if (i_reset && m_txq.size() != 0) chk("w_data", o_w_data, m_txq[0]);
      if (o_wr_uart) begin wlog.push_back(o_w_data); last_wr_cyc = cyc; end
      if (o_done) n_done++;
      if (o_timeout) begin n_tmo++; tmo_cyc = cyc; end
      if (o_stray) n_stray++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int w0, nd, nt, ns;
    logic [7:0] ops [8];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};

    // Reset
    tick();
    chk_en = 1;
    tick();
    i_reset = 1'b1;
    chk("reset_busy", o_busy, 0);
    chk("reset_result", o_result, 8'h00);
    tick();

    // TX backpressure entering SEND_B
    w0 = wlog.size();
    send_req(8'h11, 8'h22, OP_SUB);
    tick();
    i_tx_full = 1'b1;
    repeat (4) tick();
    i_tx_full = 1'b0;
    wait_wait(10);
    push_rx(8'h33);
    wait_idle(10);
    chk("bp_nwr", wlog.size() - w0, 3);
    chk("bp_a",  wlog[w0],   8'h11);
    chk("bp_b",  wlog[w0+1], 8'h22);
    chk("bp_op", wlog[w0+2], 8'h22);

    // Basic ADD
    w0 = wlog.size(); nd = n_done;
    send_req(8'h05, 8'h03, OP_ADD);
    wait_wait(10);
    repeat (3) tick();
    push_rx(8'h08);
    wait_idle(10);
    tick();
    chk("add_nwr", wlog.size() - w0, 3);
    chk("add_a",  wlog[w0],   8'h05);
    chk("add_b",  wlog[w0+1], 8'h03);
    chk("add_op", wlog[w0+2], 8'h20);
    chk("add_result", o_result, 8'h08);
    chk("add_ndone", n_done - nd, 1);
    chk("add_busy_after", o_busy, 0);

    // Timeout with no response
    nd = n_done; nt = n_tmo;
    send_req(8'h07, 8'h09, OP_AND);
    wait_idle(60);
    tick();
    chk("tmo_count", n_tmo - nt, 1);
    chk("tmo_latency", tmo_cyc - last_wr_cyc, 17);
    chk("tmo_no_done", n_done - nd, 0);
    chk("tmo_result", o_result, 8'h08);
    chk("tmo_idle", o_busy, 0);

    // Stray byte on the start cycle
    w0 = wlog.size(); ns = n_stray;
    push_rx(8'hAA);
    send_req(8'h0C, 8'h0A, OP_XOR);
    wait_wait(10);
    push_rx(8'h06);
    wait_idle(10);
    tick();
    chk("stray_count", n_stray - ns, 1);
    chk("stray_nwr", wlog.size() - w0, 3);
    chk("stray_result", o_result, 8'h06);

    // Reset mid-frame in SEND_B
    w0 = wlog.size();
    send_req(8'h31, 8'h32, OP_OR);
    tick();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_wr", o_wr_uart, 0);
    chk("rst_mid_result", o_result, 8'h00);
    repeat (5) tick();
    chk("rst_mid_nwr", wlog.size() - w0, 1);
    w0 = wlog.size();
    send_req(8'h41, 8'h42, OP_NOR);
    wait_wait(10);
    push_rx(8'h77);
    wait_idle(10);
    chk("rst_new_nwr", wlog.size() - w0, 3);
    chk("rst_new_a", wlog[w0], 8'h41);

    // Start while busy is ignored
    w0 = wlog.size(); nd = n_done;
    send_req(8'h40, 8'h02, OP_SRL);
    wait_wait(10);
    i_data_a = 8'hEE; i_data_b = 8'hDD; i_opcode = OP_ADD; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    push_rx(8'h10);
    wait_idle(10);
    repeat (8) tick();
    chk("busy_start_nwr", wlog.size() - w0, 3);
    chk("busy_start_a", wlog[w0], 8'h40);
    chk("busy_start_op", wlog[w0+2], 8'h02);
    chk("busy_start_ndone", n_done - nd, 1);
    chk("busy_start_result", o_result, 8'h10);

    // Randomized traffic: backpressure, reply delays (some past the limit),
    // stray bytes and spurious starts.
    for (int r = 0; r < 40; r++) begin
      int  d;
      bit  pushed;
      d = $urandom_range(0, 20);
      pushed = 0;
      if ($urandom_range(0, 3) == 0) push_rx(8'($urandom));
      send_req(8'($urandom), 8'($urandom), ops[$urandom_range(0, 7)][5:0]);
      for (int k = 0; k < 200 && !m_idle(); k++) begin
        i_tx_full = ($urandom_range(0, 3) == 0);
        i_start   = ($urandom_range(0, 7) == 0);
        i_data_a  = 8'($urandom);
        if (m_wait && m_age == d && !pushed) begin
          push_rx(8'($urandom));
          pushed = 1;
        end
        tick();
      end
      i_start = 1'b0;
      i_tx_full = 1'b0;
      if (!m_idle()) chk("rand_reach_idle", 0, 1);
      tick();
    end
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_master.md
Name: alu_uart_master

Overview:
- Host-side initiator for the UART ALU command protocol. It sends a 3-byte frame to the remote ALU responder: operand A, operand B, then opcode.
- After the frame, it waits for the single result byte coming back.
- It sits between a local requester (test controller or pushbutton logic) and the `uart` block's FIFO interface (`w_data`/`wr_uart`/`tx_full`, `r_data`/`rd_uart`/`rx_empty`).
- It provides request/done handshaking and a response timeout.

Parameters:
- BUS_SIZE, 8, width of UART data bytes, operands and result.
- NB_OP, 6, width of the ALU opcode. Zero-extended to BUS_SIZE on transmit; must be <= BUS_SIZE.
- TIMEOUT_CYCLES, 100000, clock cycles to wait for the result byte. 0 disables the timeout.

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_start  in  1  request strobe, accepted only in IDLE
- i_data_a  in  BUS_SIZE  operand A
- i_data_b  in  BUS_SIZE  operand B
- i_opcode  in  NB_OP  ALU operation code
- o_w_data  out  BUS_SIZE  byte to UART TX FIFO
- o_wr_uart  out  1  TX FIFO write strobe
- i_tx_full  in  1  TX FIFO full
- i_r_data  in  BUS_SIZE  head byte of UART RX FIFO
- o_rd_uart  out  1  RX FIFO pop strobe
- i_rx_empty  in  1  RX FIFO empty
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse, result valid
- o_timeout  out  1  one-cycle pulse, no response within TIMEOUT_CYCLES
- o_stray  out  1  one-cycle pulse, unsolicited RX byte discarded in IDLE
- o_result  out  BUS_SIZE  last received result, registered

Behaviour:
- Reset: one clock, reset is synchronous and active-low.
  - While i_reset==0 at a rising edge: state<=IDLE; operand/opcode registers, o_result, timeout counter <=0.
  - o_busy, o_done, o_timeout, o_stray are 0 after reset.
  - o_wr_uart=0 and o_rd_uart=0 while in reset.
  - Reset mid-frame aborts the frame. Bytes already in the FIFOs are left untouched.
- States: IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RX, DONE.
- IDLE:
  - i_start=1 latches a, b and the zero-extended opcode; next state SEND_A.
  - If i_rx_empty=0: o_rd_uart=1 (combinational) and o_stray pulses the next cycle. This also happens on a start cycle.
- SEND_A / SEND_B / SEND_OP:
  - o_w_data = latched a / b / opcode.
  - o_wr_uart = ~i_tx_full (combinational).
  - Advance only on a cycle with o_wr_uart=1; otherwise hold state and data.
  - With no backpressure, the three writes occur on 3 consecutive cycles starting the cycle after start.
  - Leaving SEND_OP clears the timeout counter; next state WAIT_RX.
- WAIT_RX:
  - If i_rx_empty=0: o_rd_uart=1, o_result<=i_r_data, next state DONE.
  - Else the counter increments.
  - When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with the FIFO still empty: o_timeout pulses the next cycle, next state IDLE, o_result unchanged.
  - A byte arriving on the same cycle the limit is reached wins; no timeout is reported.
- DONE: o_done=1 for exactly one cycle, then IDLE. Total request-to-done latency with no stalls = 5 + response wait cycles.
- i_start outside IDLE is ignored (no queueing).
- o_rd_uart and o_wr_uart are never asserted while the corresponding FIFO is empty or full.
- The timeout counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.

Decomposition:
- Package alu_uart_pkg holds:
  - state encodings (3-bit localparams);
  - protocol byte order constants (index 0=A, 1=B, 2=OP);
  - ALU opcode constants shared with the responder and the ALU (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, SRA 6'h03, SRL 6'h02, NOR 6'h27).
- One sub-module: alu_uart_timeout_counter (clear, enable, parameter limit, expired flag).
- FSM and datapath stay in alu_uart_master.

Test Plan:
- Basic ADD:
  - Stimulus: start with a=0x05, b=0x03, op=0x20; FIFO model returns 0x08 three cycles later.
  - Response: o_w_data 05, 03, 20 on 3 consecutive o_wr_uart cycles; one o_rd_uart; o_result=0x08; o_done pulses once; o_busy falls with the done pulse.
- TX backpressure: i_tx_full=1 for 4 cycles entering SEND_B → no writes during stall, o_w_data held at b, byte sequence intact, exactly 3 writes total.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, previous o_result=0x08, no response byte.
  - Response: o_timeout pulses 16 cycles after entering WAIT_RX; o_done stays 0; o_result stays 0x08; back in IDLE.
- Stray byte: 0xAA in RX FIFO while IDLE, same cycle as i_start → 0xAA popped, o_stray pulses, frame sent normally, o_result not 0xAA.
- Reset mid-frame: i_reset=0 for one edge while in SEND_B → IDLE next cycle, all outputs 0, no further writes. A new start then sends the full 3-byte frame.
- Start while busy: second i_start during WAIT_RX with different operands → ignored; only one frame sent; result from the first request.
